// File: rtl/sig_decoder_pkg.sv
// Shared types and field positions for the software signature protocol.
// Signature words carry an 8-bit type in [7:0] and a type-specific payload above it.
package riscv_signature_pkg;

    typedef enum logic [1:0] {
        CORE_STATUS = 2'd0,
        TEST_RESULT = 2'd1,
        WRITE_GPR   = 2'd2,
        WRITE_CSR   = 2'd3
    } signature_type_t;

    typedef enum logic [4:0] {
        INITIALIZED             = 5'd0,
        IN_DEBUG_MODE           = 5'd1,
        IN_MACHINE_MODE         = 5'd2,
        IN_HYPERVISOR_MODE      = 5'd3,
        IN_SUPERVISOR_MODE      = 5'd4,
        IN_USER_MODE            = 5'd5,
        HANDLING_IRQ            = 5'd6,
        FINISHED_IRQ            = 5'd7,
        HANDLING_EXCEPTION      = 5'd8,
        INSTR_FAULT_EXCEPTION   = 5'd9,
        ILLEGAL_INSTR_EXCEPTION = 5'd10,
        LOAD_FAULT_EXCEPTION    = 5'd11,
        STORE_FAULT_EXCEPTION   = 5'd12,
        EBREAK_EXCEPTION        = 5'd13
    } core_status_t;

    typedef enum logic {
        TEST_PASS = 1'b0,
        TEST_FAIL = 1'b1
    } test_result_t;

    localparam int unsigned SigTypeLsb = 0;
    localparam int unsigned SigTypeW   = 8;
    localparam int unsigned StatusLsb  = 8;
    localparam int unsigned StatusW    = 5;
    localparam int unsigned ResultBit  = 8;
    localparam int unsigned CsrAddrLsb = 20;
    localparam int unsigned CsrAddrW   = 12;
    localparam int unsigned GprIdxW    = 5;

    localparam logic [StatusW-1:0] MaxCoreStatus = 5'd13;

    typedef enum logic [1:0] {
        IDLE,
        GPR_DUMP,
        CSR_VAL
    } sig_dec_state_e;

    // Event metadata; the data value travels alongside so its width can follow DataWidth.
    typedef struct packed {
        signature_type_t        sig_type;
        core_status_t           status;
        test_result_t           result;
        logic [GprIdxW-1:0]     gpr_idx;
        logic [CsrAddrW-1:0]    csr_addr;
    } sig_evt_t;

endpackage

// File: rtl/sig_decoder_if.sv
// Write-snoop channel and decoded-event channel of the signature decoder.
// master = bus/harness side, slave = decoder side.
interface sig_decoder_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [1:0]           evt_type;
    logic [4:0]           evt_status;
    logic                 evt_result;
    logic [4:0]           evt_gpr_idx;
    logic [11:0]          evt_csr_addr;
    logic [DataWidth-1:0] evt_value;

    modport master (
        output wr_valid, wr_addr, wr_data, evt_ready,
        input  wr_ready, evt_valid, evt_type, evt_status, evt_result,
               evt_gpr_idx, evt_csr_addr, evt_value
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, evt_ready,
        output wr_ready, evt_valid, evt_type, evt_status, evt_result,
               evt_gpr_idx, evt_csr_addr, evt_value
    );
endinterface

// File: rtl/sig_decoder_evt_reg.sv
// Single-entry valid/ready output register for decoded events.
// Accepts a new event in the same cycle the held one drains.
module sig_evt_reg
    import riscv_signature_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  sig_evt_t             in_evt,
    input  logic [DataWidth-1:0] in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output sig_evt_t             out_evt,
    output logic [DataWidth-1:0] out_value
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_evt   <= '0;
            out_value <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_evt   <= in_evt;
            out_value <= in_value;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_evt   <= '0;
            out_value <= '0;
        end
    end

endmodule

// File: rtl/sig_decoder.sv
// Passive signature-protocol receiver: snoops writes to SigAddr and emits one
// decoded event per completed CORE_STATUS / TEST_RESULT / WRITE_GPR / WRITE_CSR item.
module sig_decoder
    import riscv_signature_pkg::*;
#(
    parameter int unsigned         DataWidth = 32,
    parameter int unsigned         AddrWidth = 32,
    parameter logic [AddrWidth-1:0] SigAddr  = AddrWidth'(32'h8FFF_FFFC),
    parameter int unsigned         NumGpr    = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sig_decoder_if.slave  bus,
    output logic          test_done_o,
    output logic          test_pass_o,
    output logic          proto_err_o
);

    localparam logic [GprIdxW-1:0] LastGprIdx = GprIdxW'(NumGpr - 1);

    sig_dec_state_e       state_q, state_d;
    logic [GprIdxW-1:0]   cnt_q, cnt_d;
    logic [CsrAddrW-1:0]  csr_q, csr_d;

    logic                 wr_ready;
    logic                 sig_write;
    logic [DataWidth-1:0] word;
    logic [SigTypeW-1:0]  word_type;
    logic [StatusW-1:0]   word_status;

    logic                 emit;
    sig_evt_t             evt_d;
    logic [DataWidth-1:0] value_d;
    logic                 result_seen;
    logic                 err_set;

    sig_evt_t             evt_q;

    // Non-signature writes are accepted too, but never reach the decoder.
    assign sig_write   = bus.wr_valid && wr_ready && (bus.wr_addr == SigAddr);
    assign word        = bus.wr_data;
    assign word_type   = word[SigTypeLsb +: SigTypeW];
    assign word_status = word[StatusLsb +: StatusW];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        csr_d       = csr_q;
        emit        = 1'b0;
        evt_d       = '0;
        value_d     = '0;
        result_seen = 1'b0;
        err_set     = 1'b0;

        if (sig_write) begin
            unique case (state_q)
                IDLE: begin
                    case (word_type)
                        8'd0: begin
                            emit           = 1'b1;
                            evt_d.sig_type = CORE_STATUS;
                            evt_d.status   = core_status_t'(word_status);
                            err_set        = (word_status > MaxCoreStatus);
                        end
                        8'd1: begin
                            emit           = 1'b1;
                            evt_d.sig_type = TEST_RESULT;
                            evt_d.result   = test_result_t'(word[ResultBit]);
                            result_seen    = 1'b1;
                        end
                        8'd2: begin
                            state_d = GPR_DUMP;
                            cnt_d   = '0;
                        end
                        8'd3: begin
                            state_d = CSR_VAL;
                            csr_d   = word[CsrAddrLsb +: CsrAddrW];
                        end
                        default: err_set = 1'b1;
                    endcase
                end
                GPR_DUMP: begin
                    emit           = 1'b1;
                    evt_d.sig_type = WRITE_GPR;
                    evt_d.gpr_idx  = cnt_q;
                    value_d        = word;
                    cnt_d          = cnt_q + 1'b1;
                    if (cnt_q == LastGprIdx) begin
                        state_d = IDLE;
                    end
                end
                CSR_VAL: begin
                    emit           = 1'b1;
                    evt_d.sig_type = WRITE_CSR;
                    evt_d.csr_addr = csr_q;
                    value_d        = word;
                    state_d        = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            csr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            csr_q   <= csr_d;
        end
    end

    // Only the first TEST_RESULT after reset decides pass/fail.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            test_done_o <= 1'b0;
            test_pass_o <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (result_seen) begin
                test_done_o <= 1'b1;
                if (!test_done_o) begin
                    test_pass_o <= (evt_d.result == TEST_PASS);
                end
            end
            if (err_set) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    sig_evt_reg #(
        .DataWidth (DataWidth)
    ) u_evt_reg (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_valid  (emit),
        .in_ready  (wr_ready),
        .in_evt    (evt_d),
        .in_value  (value_d),
        .out_valid (bus.evt_valid),
        .out_ready (bus.evt_ready),
        .out_evt   (evt_q),
        .out_value (bus.evt_value)
    );

    assign bus.wr_ready     = wr_ready;
    assign bus.evt_type     = evt_q.sig_type;
    assign bus.evt_status   = evt_q.status;
    assign bus.evt_result   = evt_q.result;
    assign bus.evt_gpr_idx  = evt_q.gpr_idx;
    assign bus.evt_csr_addr = evt_q.csr_addr;

endmodule

// File: doc/sig_decoder.md
Name: sig_decoder

Overview:
Passive receiver for the software signature protocol. The test program writes signature words to one fixed address; this block snoops a data-bus write channel, decodes CORE_STATUS, TEST_RESULT, WRITE_GPR and WRITE_CSR sequences, and emits one decoded event per completed item. It sits beside the core's data port in the testbench/SoC harness and feeds monitors, scoreboards and the end-of-test logic.

Parameters:
DataWidth, 32, width of bus data and of signature words
AddrWidth, 32, width of bus address
SigAddr, 32'h8FFF_FFFC, byte address of the signature register
NumGpr, 32, GPR words following a WRITE_GPR header

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
wr_valid_i  in  1  bus write valid
wr_ready_o  out  1  write accepted when wr_valid_i & wr_ready_o
wr_addr_i  in  AddrWidth  write byte address
wr_data_i  in  DataWidth  write data
evt_valid_o  out  1  decoded event valid
evt_ready_i  in  1  event consumer ready
evt_type_o  out  2  signature_type_t of event
evt_status_o  out  5  core_status_t (CORE_STATUS events)
evt_result_o  out  1  test_result_t (TEST_RESULT events)
evt_gpr_idx_o  out  5  GPR index (WRITE_GPR events)
evt_csr_addr_o  out  12  CSR address (WRITE_CSR events)
evt_value_o  out  DataWidth  GPR/CSR value
test_done_o  out  1  sticky: TEST_RESULT seen
test_pass_o  out  1  sticky: result of first TEST_RESULT was TEST_PASS
proto_err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: all outputs 0 except wr_ready_o = 1; FSM in IDLE; GPR counter 0.
- Word format: [7:0] type; CORE_STATUS status in [12:8]; TEST_RESULT result in [8]; WRITE_CSR header CSR address in [31:20].
- wr_ready_o = !evt_valid_o | evt_ready_i (single-entry output register). Writes are accepted at any address. Non-SigAddr writes are dropped with no state change.
- An accepted sig write at cycle N that completes an item asserts evt_valid_o at N+1. The event payload holds until evt_valid_o & evt_ready_i. Unused payload fields are driven 0.
- FSM states:
  - IDLE, on a sig write:
    - type 0: emit CORE_STATUS. A status value > 13 is still emitted raw and also sets proto_err_o.
    - type 1: emit TEST_RESULT. Set test_done_o; latch test_pass_o only if test_done_o was 0.
    - type 2: go to GPR_DUMP with cnt = 0; no event.
    - type 3: latch CSR address; go to CSR_VAL; no event.
    - type > 3: set proto_err_o; stay in IDLE; no event.
  - GPR_DUMP, on each sig write: emit WRITE_GPR with idx = cnt and value = data; cnt++. The write with cnt = NumGpr-1 returns to IDLE. Data is never type-decoded here.
  - CSR_VAL, on a sig write: emit WRITE_CSR with the latched address and value = data; go to IDLE.
- Back-pressure: while the event register is occupied and evt_ready_i = 0, wr_ready_o = 0. No write is lost. Same-cycle drain and accept is allowed, giving full throughput.
- test_done_o, test_pass_o and proto_err_o are sticky until reset.
- Reset asserted mid-sequence (GPR_DUMP/CSR_VAL) aborts the sequence immediately and drops any pending event.

Decomposition:
- riscv_signature_pkg holds signature_type_t, core_status_t, test_result_t, plus new constants: SigTypeLsb = 0, SigTypeW = 8, StatusLsb = 8, ResultBit = 8, CsrAddrLsb = 20, and an enum sig_dec_state_e {IDLE, GPR_DUMP, CSR_VAL}.
- One natural sub-module: sig_evt_reg, a single-entry valid/ready output register carrying the packed event struct, also defined in the package.

Test Plan:
1. Write 0x0000_0200 (CORE_STATUS, IN_MACHINE_MODE) with evt_ready_i = 1 -> next cycle evt_valid_o = 1, type 0, status 2, proto_err_o = 0.
2. Write header 0x02, then 32 words 0x100+i -> 32 events with idx 0..31 and value 0x100+i; the 33rd write 0x0000_0001 -> TEST_RESULT event, result 0, test_done_o = 1, test_pass_o = 1.
3. Write 0x3000_0003 then 0xDEAD_BEEF -> one WRITE_CSR event, csr_addr 0x300, value 0xDEADBEEF; the header produces no event.
4. evt_ready_i = 0 for 5 cycles during a GPR dump -> wr_ready_o = 0 after the first event; on release, all 32 events arrive in order with none lost or duplicated.
5. Write 0x07 to SigAddr -> proto_err_o = 1, no event. A write 0x01 to SigAddr-4 -> no event, no state change.
6. rst_ni pulled low mid-cycle after 10 GPR words -> outputs clear asynchronously. After release, write 0x0000_0101 -> TEST_RESULT event with result 1, and test_pass_o stays 0.
